knn_pio_bridge: RTL and testbench

//  Sits between the NIOS2 SOPC KNN PIO exports and the KNN compute core.
//  - Decodes software-driven attribute/value/pronto writes into feature vectors.
//  - Training mode: commits each vector plus its class label to the core sample store.
//  - Classify mode: issues each vector as a query to the core.
//  - Returns the predicted class to the PIO inputs, with a ready flag.

---
 rtl/knn_pio_bridge.sv | 128 ++++++++++++
 tb/tb_knn_pio_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/knn_pio_bridge.sv
// knn_pio_bridge: decodes KNN PIO writes into training samples or queries and returns the predicted class
module knn_pio_bridge #(
  parameter int N_ATTR      = 4,
  parameter int W_VAL       = 16,
  parameter int MAX_SAMPLES = 64,
  parameter int AW          = 6
) (
  input  logic                    clk50,
  input  logic                    reset,
  input  logic                    knn_reset_out_export,
  input  logic                    knn_treinamento_out_export,
  input  logic [3:0]              knn_k_export,
  input  logic [7:0]              knn_dados_atributo_out_export,
  input  logic [W_VAL-1:0]        knn_dados_valor_out_export,
  input  logic                    knn_dados_pronto_out_export,
  output logic [15:0]             knn_classe_prevista_in_export,
  output logic                    knn_classe_prevista_pronto_in_export,
  output logic                    core_clear,
  output logic                    trn_wr_en,
  output logic [AW-1:0]           trn_wr_addr,
  output logic [N_ATTR*W_VAL-1:0] trn_wr_data,
  output logic [W_VAL-1:0]        trn_wr_label,
  output logic [AW:0]             sample_count,
  output logic                    qry_valid,
  input  logic                    qry_ready,
  output logic [N_ATTR*W_VAL-1:0] qry_data,
  output logic [3:0]              qry_k,
  output logic [AW:0]             qry_count,
  input  logic                    res_valid,
  input  logic [15:0]             res_class,
  output logic                    err_flag
);
  typedef enum logic [1:0] {IDLE, QUERY, WAIT_RES} state_t;
  localparam logic [7:0] NA = 8'(N_ATTR);
  localparam logic [AW:0] MAXC = (AW+1)'(MAX_SAMPLES);
  localparam int IW = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
  state_t state, state_nx;
  logic pronto_q, arm, soft_q, sc, ev, commit;
  logic [N_ATTR-1:0][W_VAL-1:0] vec;
  logic [W_VAL-1:0] label;
  logic [3:0] k_eff;
  logic [7:0] code;
  assign code = knn_dados_atributo_out_export;
  assign sc = knn_reset_out_export & ~soft_q;
  assign ev = knn_dados_pronto_out_export & ~pronto_q & arm & ~sc;
  assign commit = ev & (code == 8'hFF);
  assign k_eff = (knn_k_export == 4'd0) ? 4'd1 :
                 ((AW+1)'(knn_k_export) > sample_count) ? sample_count[3:0] : knn_k_export;
  always_ff @(posedge clk50)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = sc ? IDLE :
               (state == IDLE && commit && !knn_treinamento_out_export && sample_count != '0) ? QUERY :
               (state == QUERY && qry_ready) ? WAIT_RES :
               (state == WAIT_RES && res_valid) ? IDLE : state;
  always_ff @(posedge clk50) begin
    if (reset) begin
      pronto_q <= 1'b0;
      arm <= 1'b0;
      soft_q <= 1'b0;
      vec <= '0;
      label <= '0;
      sample_count <= '0;
      knn_classe_prevista_in_export <= '0;
      knn_classe_prevista_pronto_in_export <= 1'b0;
      core_clear <= 1'b0;
      trn_wr_en <= 1'b0;
      trn_wr_addr <= '0;
      trn_wr_data <= '0;
      trn_wr_label <= '0;
      qry_valid <= 1'b0;
      qry_data <= '0;
      qry_k <= '0;
      qry_count <= '0;
      err_flag <= 1'b0;
    end else begin
      pronto_q <= knn_dados_pronto_out_export;
      arm <= arm | ~knn_dados_pronto_out_export;
      soft_q <= knn_reset_out_export;
      core_clear <= sc;
      trn_wr_en <= 1'b0;
      if (sc) begin
        sample_count <= '0;
        vec <= '0;
        label <= '0;
        err_flag <= 1'b0;
        qry_valid <= 1'b0;
        knn_classe_prevista_pronto_in_export <= 1'b0;
      end else begin
        if (ev && code < NA) vec[code[IW-1:0]] <= knn_dados_valor_out_export;
        if (ev && code == 8'hFE) label <= knn_dados_valor_out_export;
        if (ev && code >= NA && code < 8'hFE) err_flag <= 1'b1;
        if (res_valid && state != WAIT_RES) err_flag <= 1'b1;
        if (state == QUERY && qry_ready) qry_valid <= 1'b0;
        if (state == WAIT_RES && res_valid) begin
          knn_classe_prevista_in_export <= res_class;
          knn_classe_prevista_pronto_in_export <= 1'b1;
        end
        if (commit) begin
          if (state != IDLE) err_flag <= 1'b1;
          else begin
            vec <= '0;
            if (knn_treinamento_out_export) begin
              label <= '0;
              if (sample_count == MAXC) err_flag <= 1'b1;
              else begin
                trn_wr_en <= 1'b1;
                trn_wr_addr <= sample_count[AW-1:0];
                trn_wr_data <= vec;
                trn_wr_label <= label;
                sample_count <= sample_count + (AW+1)'(1);
              end
            end else if (sample_count == '0) begin
              knn_classe_prevista_in_export <= 16'hFFFF;
              knn_classe_prevista_pronto_in_export <= 1'b1;
            end else begin
              qry_valid <= 1'b1;
              qry_data <= vec;
              qry_k <= k_eff;
              qry_count <= sample_count;
              knn_classe_prevista_pronto_in_export <= 1'b0;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_knn_pio_bridge.sv
// tb_knn_pio_bridge: directed scoreboard bench for knn_pio_bridge
module tb_knn_pio_bridge;
  logic clk50 = 1'b0, reset = 1'b1;
  logic knn_reset_out_export = 1'b0, knn_treinamento_out_export = 1'b0;
  logic [3:0] knn_k_export = '0;
  logic [7:0] knn_dados_atributo_out_export = '0;
  logic [15:0] knn_dados_valor_out_export = '0;
  logic knn_dados_pronto_out_export = 1'b0;
  logic [15:0] knn_classe_prevista_in_export;
  logic knn_classe_prevista_pronto_in_export;
  logic core_clear, trn_wr_en, qry_valid, err_flag;
  logic qry_ready = 1'b0, res_valid = 1'b0;
  logic [15:0] res_class = '0;
  logic [5:0] trn_wr_addr;
  logic [63:0] trn_wr_data, qry_data;
  logic [15:0] trn_wr_label;
  logic [6:0] sample_count, qry_count;
  logic [3:0] qry_k;
  int tests = 0, fails = 0;
  logic [85:0] wr_q[$];
  logic [74:0] qry_q[$];
  logic [15:0] res_q[$];
  logic [85:0] ew;
  logic [74:0] eq;
  logic [15:0] er;
  logic prev_pr = 1'b0;
  knn_pio_bridge dut (
    .clk50(clk50), .reset(reset),
    .knn_reset_out_export(knn_reset_out_export),
    .knn_treinamento_out_export(knn_treinamento_out_export),
    .knn_k_export(knn_k_export),
    .knn_dados_atributo_out_export(knn_dados_atributo_out_export),
    .knn_dados_valor_out_export(knn_dados_valor_out_export),
    .knn_dados_pronto_out_export(knn_dados_pronto_out_export),
    .knn_classe_prevista_in_export(knn_classe_prevista_in_export),
    .knn_classe_prevista_pronto_in_export(knn_classe_prevista_pronto_in_export),
    .core_clear(core_clear), .trn_wr_en(trn_wr_en), .trn_wr_addr(trn_wr_addr),
    .trn_wr_data(trn_wr_data), .trn_wr_label(trn_wr_label), .sample_count(sample_count),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_data(qry_data), .qry_k(qry_k),
    .qry_count(qry_count), .res_valid(res_valid), .res_class(res_class), .err_flag(err_flag)
  );
  always #5 clk50 = ~clk50;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk50) begin
    if (!reset) begin
      if (trn_wr_en) begin
        if (wr_q.size() == 0) chk("unexpected_wr", 64'd1, 64'd0);
        else begin
          ew = wr_q.pop_front();
          chk("wr_addr", 64'(trn_wr_addr), 64'(ew[85:80]));
          chk("wr_data", trn_wr_data, ew[79:16]);
          chk("wr_label", 64'(trn_wr_label), 64'(ew[15:0]));
        end
      end
      if (qry_valid && qry_ready) begin
        if (qry_q.size() == 0) chk("unexpected_qry", 64'd1, 64'd0);
        else begin
          eq = qry_q.pop_front();
          chk("qry_data", qry_data, eq[74:11]);
          chk("qry_k", 64'(qry_k), 64'(eq[10:7]));
          chk("qry_count", 64'(qry_count), 64'(eq[6:0]));
        end
      end
      if (knn_classe_prevista_pronto_in_export && !prev_pr) begin
        if (res_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else begin
          er = res_q.pop_front();
          chk("result_class", 64'(knn_classe_prevista_in_export), 64'(er));
        end
      end
    end
    prev_pr = knn_classe_prevista_pronto_in_export;
  end
  task automatic strobe(input logic [7:0] c, input logic [15:0] v);
    @(posedge clk50); #1;
    knn_dados_atributo_out_export = c;
    knn_dados_valor_out_export = v;
    knn_dados_pronto_out_export = 1'b1;
    @(posedge clk50); #1;
    knn_dados_pronto_out_export = 1'b0;
  endtask
  task automatic soft_clear();
    @(posedge clk50); #1;
    knn_reset_out_export = 1'b1;
    @(posedge clk50); #1;
    chk("sc_core_clear", 64'(core_clear), 64'd1);
    chk("sc_count", 64'(sample_count), 64'd0);
    chk("sc_err", 64'(err_flag), 64'd0);
    chk("sc_qry_valid", 64'(qry_valid), 64'd0);
    chk("sc_pronto", 64'(knn_classe_prevista_pronto_in_export), 64'd0);
    @(posedge clk50); #1;
    chk("sc_core_clear_pulse", 64'(core_clear), 64'd0);
    knn_reset_out_export = 1'b0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask
  initial begin
    knn_treinamento_out_export = 1'b1;
    knn_dados_atributo_out_export = 8'hFF;
    knn_dados_pronto_out_export = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(3);
    chk("rst_class", 64'(knn_classe_prevista_in_export), 64'd0);
    chk("rst_pronto", 64'(knn_classe_prevista_pronto_in_export), 64'd0);
    chk("rst_qry_valid", 64'(qry_valid), 64'd0);
    chk("rst_err", 64'(err_flag), 64'd0);
    chk("held_pronto_count", 64'(sample_count), 64'd0);
    knn_dados_pronto_out_export = 1'b0;
    cycles(1);
    wr_q.push_back({6'd0, 64'h0028_001E_0014_000A, 16'd2});
    strobe(8'd0, 16'd10); strobe(8'd1, 16'd20); strobe(8'd2, 16'd30); strobe(8'd3, 16'd40);
    strobe(8'hFE, 16'd2); strobe(8'hFF, 16'd0);
    cycles(1);
    chk("train_count1", 64'(sample_count), 64'd1);
    wr_q.push_back({6'd1, 64'h0000_0000_0000_0001, 16'd5});
    strobe(8'd0, 16'd1); strobe(8'hFE, 16'd5); strobe(8'hFF, 16'd0);
    wr_q.push_back({6'd2, 64'h0007_0000_0000_0000, 16'd6});
    strobe(8'd3, 16'd7); strobe(8'hFE, 16'd6); strobe(8'hFF, 16'd0);
    chk("train_count3", 64'(sample_count), 64'd3);
    knn_treinamento_out_export = 1'b0;
    knn_k_export = 4'd5;
    qry_q.push_back({64'h0004_0003_0002_0001, 4'd3, 7'd3});
    strobe(8'd0, 16'd1); strobe(8'd1, 16'd2); strobe(8'd2, 16'd3); strobe(8'd3, 16'd4);
    strobe(8'hFF, 16'd0);
    chk("q_valid", 64'(qry_valid), 64'd1);
    chk("q_k_clamped", 64'(qry_k), 64'd3);
    chk("q_count", 64'(qry_count), 64'd3);
    strobe(8'd0, 16'd55);
    chk("q_hold_data_a", qry_data, 64'h0004_0003_0002_0001);
    strobe(8'hFF, 16'd0);
    chk("q_hold_data_b", qry_data, 64'h0004_0003_0002_0001);
    chk("q_hold_valid", 64'(qry_valid), 64'd1);
    chk("commit_in_query_err", 64'(err_flag), 64'd1);
    @(posedge clk50); #1;
    qry_ready = 1'b1;
    @(posedge clk50); #1;
    qry_ready = 1'b0;
    chk("q_after_hs", 64'(qry_valid), 64'd0);
    res_q.push_back(16'd7);
    @(posedge clk50); #1;
    res_valid = 1'b1; res_class = 16'd7;
    @(posedge clk50); #1;
    res_valid = 1'b0;
    chk("res_pronto", 64'(knn_classe_prevista_pronto_in_export), 64'd1);
    chk("res_class", 64'(knn_classe_prevista_in_export), 64'd7);
    soft_clear();
    chk("class_held", 64'(knn_classe_prevista_in_export), 64'd7);
    res_q.push_back(16'hFFFF);
    strobe(8'hFF, 16'd0);
    chk("empty_pronto", 64'(knn_classe_prevista_pronto_in_export), 64'd1);
    chk("empty_class", 64'(knn_classe_prevista_in_export), 64'hFFFF);
    chk("empty_no_qry", 64'(qry_valid), 64'd0);
    strobe(8'd0, 16'd11);
    strobe(8'h05, 16'd123);
    chk("bad_code_err", 64'(err_flag), 64'd1);
    knn_treinamento_out_export = 1'b1;
    wr_q.push_back({6'd0, 64'h0000_0000_0000_000B, 16'd0});
    strobe(8'hFF, 16'd0);
    soft_clear();
    for (int i = 0; i < 64; i++) begin
      wr_q.push_back({6'(i), 48'd0, 16'(i + 100), 16'd0});
      strobe(8'd0, 16'(i + 100));
      strobe(8'hFF, 16'd0);
    end
    chk("full_count", 64'(sample_count), 64'd64);
    chk("full_err_before", 64'(err_flag), 64'd0);
    strobe(8'd0, 16'd9);
    strobe(8'hFF, 16'd0);
    cycles(2);
    chk("overflow_count", 64'(sample_count), 64'd64);
    chk("overflow_err", 64'(err_flag), 64'd1);
    soft_clear();
    wr_q.push_back({6'd0, 64'h0000_0000_0000_004D, 16'd3});
    strobe(8'd0, 16'd77); strobe(8'hFE, 16'd3); strobe(8'hFF, 16'd0);
    knn_treinamento_out_export = 1'b0;
    knn_k_export = 4'd0;
    qry_ready = 1'b1;
    qry_q.push_back({64'h0000_0000_0008_0000, 4'd1, 7'd1});
    strobe(8'd1, 16'd8);
    strobe(8'hFF, 16'd0);
    chk("k0_qry_k", 64'(qry_k), 64'd1);
    @(posedge clk50); #1;
    qry_ready = 1'b0;
    chk("k0_hs_done", 64'(qry_valid), 64'd0);
    soft_clear();
    @(posedge clk50); #1;
    res_valid = 1'b1; res_class = 16'd9;
    @(posedge clk50); #1;
    res_valid = 1'b0;
    cycles(2);
    chk("discard_pronto", 64'(knn_classe_prevista_pronto_in_export), 64'd0);
    chk("discard_class", 64'(knn_classe_prevista_in_export), 64'hFFFF);
    chk("stray_res_err", 64'(err_flag), 64'd1);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("qry_q_drained", 64'(qry_q.size()), 64'd0);
    chk("res_q_drained", 64'(res_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
